// File: rtl/audio_buffer_player.sv
// audio_buffer_player: reads 4-byte little-endian stereo frames from the active
// half of a ping-pong byte buffer at the sample rate, swaps halves when the
// writer has refilled the other one, and repeats held samples while starved.
// Optional feature macro: PLAYER_PWM_OUT_EN (8-bit PWM DAC on both channels).
module audio_buffer_player #(
   parameter int unsigned BUFFER_ADDR_BITS = 9,
   parameter int unsigned SAMPLE_DIV       = 4535
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        enable_i,
   output logic [BUFFER_ADDR_BITS-1:0] buffer_rd_address_o,
   output logic                        buffer_active_sel_o,
   input  logic [7:0]                  ram_rd_data_i,
   input  logic                        audio_buffer_filled_i,
   output logic                        audio_buffer_empty_o,
   output logic signed [15:0]          sample_left_o,
   output logic signed [15:0]          sample_right_o,
   output logic                        sample_valid_o,
   output logic                        underrun_o,
   output logic                        pwm_left_o,
   output logic                        pwm_right_o
);

   localparam int unsigned AW = BUFFER_ADDR_BITS;
   localparam int unsigned CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
   localparam logic [CW-1:0] TICK_LAST = CW'(SAMPLE_DIV - 1);

   typedef enum logic [1:0] {
      S_WAIT_FILL = 2'd0,
      S_IDLE      = 2'd1,
      S_FETCH     = 2'd2,
      S_SWAP      = 2'd3
   } state_t;

   state_t        r_state, w_state_nxt;
   logic [CW-1:0] r_tick_cnt;
   logic [AW-1:0] r_addr, w_addr_nxt;
   logic          r_sel, w_sel_nxt;
   logic          r_empty, w_empty_nxt;
   logic          r_valid, w_valid_nxt;
   logic          r_underrun, w_underrun_nxt;
   logic          r_drained, w_drained_nxt;
   logic [1:0]    r_phase, w_phase_nxt;
   logic [7:0]    r_byte0, w_byte0_nxt;
   logic [7:0]    r_byte1, w_byte1_nxt;
   logic [7:0]    r_byte2, w_byte2_nxt;
   logic [15:0]   r_left, w_left_nxt;
   logic [15:0]   r_right, w_right_nxt;
   logic          w_run;
   logic          w_tick;
   logic          w_swap;

   assign w_run  = enable_i && (r_state != S_WAIT_FILL);
   assign w_tick = w_run && (r_tick_cnt == TICK_LAST);

   // Sample-rate divider; frozen while paused or waiting for the first fill.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tick_cnt <= '0;
      end else if (w_run) begin
         r_tick_cnt <= w_tick ? '0 : r_tick_cnt + CW'(1);
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_WAIT_FILL;
         r_addr     <= '0;
         r_sel      <= 1'b0;
         r_empty    <= 1'b0;
         r_valid    <= 1'b0;
         r_underrun <= 1'b0;
         r_drained  <= 1'b0;
         r_phase    <= 2'd0;
         r_byte0    <= 8'd0;
         r_byte1    <= 8'd0;
         r_byte2    <= 8'd0;
         r_left     <= 16'd0;
         r_right    <= 16'd0;
      end else begin
         r_state    <= w_state_nxt;
         r_addr     <= w_addr_nxt;
         r_sel      <= w_sel_nxt;
         r_empty    <= w_empty_nxt;
         r_valid    <= w_valid_nxt;
         r_underrun <= w_underrun_nxt;
         r_drained  <= w_drained_nxt;
         r_phase    <= w_phase_nxt;
         r_byte0    <= w_byte0_nxt;
         r_byte1    <= w_byte1_nxt;
         r_byte2    <= w_byte2_nxt;
         r_left     <= w_left_nxt;
         r_right    <= w_right_nxt;
      end
   end

   // Next state: fetch four bytes per tick, swap on wrap when refilled, else starve.
   always_comb begin
      w_state_nxt    = r_state;
      w_addr_nxt     = r_addr;
      w_sel_nxt      = r_sel;
      w_empty_nxt    = 1'b0;
      w_valid_nxt    = 1'b0;
      w_underrun_nxt = r_underrun;
      w_drained_nxt  = r_drained;
      w_phase_nxt    = r_phase;
      w_byte0_nxt    = r_byte0;
      w_byte1_nxt    = r_byte1;
      w_byte2_nxt    = r_byte2;
      w_left_nxt     = r_left;
      w_right_nxt    = r_right;
      w_swap         = 1'b0;

      unique case (r_state)
         S_WAIT_FILL: begin
            w_swap = audio_buffer_filled_i;
         end
         S_IDLE: begin
            if (r_drained) begin
               // Swap wins over a coincident tick; otherwise repeat held samples.
               if (audio_buffer_filled_i) begin
                  w_swap = 1'b1;
               end else if (w_tick) begin
                  w_valid_nxt    = 1'b1;
                  w_underrun_nxt = 1'b1;
               end
            end else if (w_tick) begin
               w_state_nxt = S_FETCH;
               w_phase_nxt = 2'd0;
               w_addr_nxt  = r_addr + AW'(1);
            end
         end
         S_FETCH: begin
            w_phase_nxt = r_phase + 2'd1;
            case (r_phase)
               2'd0: begin
                  w_byte0_nxt = ram_rd_data_i;
                  w_addr_nxt  = r_addr + AW'(1);
               end
               2'd1: begin
                  w_byte1_nxt = ram_rd_data_i;
                  w_addr_nxt  = r_addr + AW'(1);
               end
               2'd2: begin
                  w_byte2_nxt = ram_rd_data_i;
                  w_addr_nxt  = r_addr + AW'(1);
               end
               default: begin
                  w_left_nxt  = {r_byte1, r_byte0};
                  w_right_nxt = {ram_rd_data_i, r_byte2};
                  w_valid_nxt = 1'b1;
                  w_state_nxt = S_IDLE;
                  // Address back at zero here means the half was just exhausted.
                  if (r_addr == '0) begin
                     if (audio_buffer_filled_i) begin
                        w_swap = 1'b1;
                     end else begin
                        w_drained_nxt = 1'b1;
                     end
                  end
               end
            endcase
         end
         S_SWAP: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_WAIT_FILL;
         end
      endcase

      if (w_swap) begin
         w_state_nxt    = S_SWAP;
         w_sel_nxt      = ~r_sel;
         w_empty_nxt    = 1'b1;
         w_underrun_nxt = 1'b0;
         w_drained_nxt  = 1'b0;
         w_addr_nxt     = '0;
      end
   end

   assign buffer_rd_address_o  = r_addr;
   assign buffer_active_sel_o  = r_sel;
   assign audio_buffer_empty_o = r_empty;
   assign sample_valid_o       = r_valid;
   assign underrun_o           = r_underrun;
   assign sample_left_o        = r_left;
   assign sample_right_o       = r_right;

`ifdef PLAYER_PWM_OUT_EN
   logic [7:0] r_pwm_cnt;
   logic       r_pwm_left;
   logic       r_pwm_right;
   logic [7:0] w_thr_left;
   logic [7:0] w_thr_right;

   // Signed sample to offset binary: flip the sign bit of the top byte.
   assign w_thr_left  = {~r_left[15], r_left[14:8]};
   assign w_thr_right = {~r_right[15], r_right[14:8]};

   // Free-running PWM ramp compared against the offset-binary thresholds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pwm_cnt   <= 8'd0;
         r_pwm_left  <= 1'b0;
         r_pwm_right <= 1'b0;
      end else begin
         r_pwm_cnt   <= r_pwm_cnt + 8'd1;
         r_pwm_left  <= (r_pwm_cnt < w_thr_left);
         r_pwm_right <= (r_pwm_cnt < w_thr_right);
      end
   end

   assign pwm_left_o  = r_pwm_left;
   assign pwm_right_o = r_pwm_right;
`else
   assign pwm_left_o  = 1'b0;
   assign pwm_right_o = 1'b0;
`endif

endmodule

// File: tb/tb_audio_buffer_player.sv
// tb_audio_buffer_player: directed playback scenarios against a frame-level
// model of the player; the RAM is a 1-cycle-latency byte array per half.
module tb_audio_buffer_player;

   localparam int unsigned AW  = 4;
   localparam int unsigned DIV = 16;

`ifdef PLAYER_PWM_OUT_EN
   localparam int DUTY_7FFF = 255;
   localparam int DUTY_8000 = 0;
   localparam int DUTY_0000 = 128;
   localparam int DUTY_0001 = 128;
`else
   localparam int DUTY_7FFF = 0;
   localparam int DUTY_8000 = 0;
   localparam int DUTY_0000 = 0;
   localparam int DUTY_0001 = 0;
`endif

   logic          clk = 1'b0;
   logic          rst_n;
   logic          enable;
   logic          filled;
   logic [AW-1:0] addr;
   logic          sel;
   logic [7:0]    ram_q = 8'd0;
   logic          empty;
   logic [15:0]   left;
   logic [15:0]   right;
   logic          valid;
   logic          under;
   logic          pwm_l;
   logic          pwm_r;

   logic [7:0]    mem [2][16];

   int vectors     = 0;
   int miscompares = 0;

   // Expected outputs for the current cycle, produced by the model.
   logic [AW-1:0] e_addr;
   logic          e_sel, e_empty, e_valid, e_under;
   logic [15:0]   e_left, e_right;
   int            m_cnt, m_age;
   bit            m_ready, m_swap, m_drained;
   logic [AW-1:0] m_base;

   audio_buffer_player #(
      .BUFFER_ADDR_BITS (AW),
      .SAMPLE_DIV       (DIV)
   ) dut (
      .clk                   (clk),
      .rst_n                 (rst_n),
      .enable_i              (enable),
      .buffer_rd_address_o   (addr),
      .buffer_active_sel_o   (sel),
      .ram_rd_data_i         (ram_q),
      .audio_buffer_filled_i (filled),
      .audio_buffer_empty_o  (empty),
      .sample_left_o         (left),
      .sample_right_o        (right),
      .sample_valid_o        (valid),
      .underrun_o            (under),
      .pwm_left_o            (pwm_l),
      .pwm_right_o           (pwm_r)
   );

   initial forever #5 clk = ~clk;

   // Byte RAM with one cycle of read latency.
   always @(posedge clk) ram_q <= mem[sel][addr];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(output int n);
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (!valid && n < 100);
      chk("valid_seen", 32'(valid), 32'd1);
   endtask

   task automatic wait_addr_move(output int n);
      n = 0;
      do begin
         @(posedge clk); #1; n++;
      end while (addr == '0 && n < 100);
      chk("addr_moved", 32'(addr != '0), 32'd1);
   endtask

   task automatic measure_duty(output int hl, output int hr);
      hl = 0; hr = 0;
      for (int i = 0; i < 256; i++) begin
         @(posedge clk); #1;
         if (pwm_l) hl++;
         if (pwm_r) hr++;
      end
   endtask

   task automatic load_frame(input int half, input int f, input logic [15:0] l, input logic [15:0] r);
      mem[half][4*f+0] = l[7:0];
      mem[half][4*f+1] = l[15:8];
      mem[half][4*f+2] = r[7:0];
      mem[half][4*f+3] = r[15:8];
   endtask

   // Frame-level model: compare this cycle, then predict the next one.
   initial begin : model_p
      logic tick, go_swap;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            e_addr = '0; e_sel = 1'b0; e_empty = 1'b0; e_valid = 1'b0; e_under = 1'b0;
            e_left = 16'd0; e_right = 16'd0;
            m_cnt = 0; m_age = 0; m_ready = 1'b0; m_swap = 1'b0; m_drained = 1'b0; m_base = '0;
         end
         chk("addr", 32'(addr), 32'(e_addr));
         chk("sel", 32'(sel), 32'(e_sel));
         chk("empty", 32'(empty), 32'(e_empty));
         chk("valid", 32'(valid), 32'(e_valid));
         chk("underrun", 32'(under), 32'(e_under));
         chk("left", 32'(left), 32'(e_left));
         chk("right", 32'(right), 32'(e_right));
`ifndef PLAYER_PWM_OUT_EN
         chk("pwm_l_zero", 32'(pwm_l), 32'd0);
         chk("pwm_r_zero", 32'(pwm_r), 32'd0);
`endif
         if (rst_n) begin
            tick = enable && m_ready && (m_cnt == DIV - 1);
            if (enable && m_ready) m_cnt = tick ? 0 : m_cnt + 1;
            e_empty = 1'b0; e_valid = 1'b0; go_swap = 1'b0;
            if (!m_ready) begin
               go_swap = filled;
            end else if (m_swap) begin
               go_swap = 1'b0;
            end else if (m_age == 4) begin
               e_valid = 1'b1;
               e_left  = {mem[e_sel][m_base + 4'd1], mem[e_sel][m_base]};
               e_right = {mem[e_sel][m_base + 4'd3], mem[e_sel][m_base + 4'd2]};
               m_base  = m_base + 4'd4;
               m_age   = 0;
               if (m_base == '0) begin
                  if (filled) go_swap = 1'b1;
                  else m_drained = 1'b1;
               end
            end else if (m_age > 0) begin
               m_age++;
               e_addr = m_base + 4'(m_age);
            end else if (m_drained) begin
               if (filled) go_swap = 1'b1;
               else if (tick) begin
                  e_valid = 1'b1;
                  e_under = 1'b1;
               end
            end else if (tick) begin
               m_age  = 1;
               e_addr = m_base + 4'd1;
            end
            m_swap = go_swap;
            if (go_swap) begin
               e_sel = ~e_sel; e_empty = 1'b1; e_under = 1'b0; e_addr = '0;
               m_base = '0; m_drained = 1'b0; m_ready = 1'b1;
            end
         end
      end
   end

   // Directed scenarios with hand-computed literal expectations.
   initial begin : stim_p
      int n, hl, hr, bad;
      logic [AW-1:0] a0;
      rst_n = 1'b0; enable = 1'b1; filled = 1'b0;
      load_frame(1, 0, 16'h1234, 16'h5678);
      load_frame(1, 1, 16'h7FFF, 16'h8000);
      load_frame(1, 2, 16'h0000, 16'h0001);
      load_frame(1, 3, 16'hABCD, 16'h1357);
      load_frame(0, 0, 16'h1111, 16'h2222);
      load_frame(0, 1, 16'h3333, 16'h4444);
      load_frame(0, 2, 16'h5555, 16'h6666);
      load_frame(0, 3, 16'hFEDC, 16'h0BA9);
      step(3);
      chk("rst_addr", 32'(addr), 32'd0);
      chk("rst_sel", 32'(sel), 32'd0);
      chk("rst_empty", 32'(empty), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_underrun", 32'(under), 32'd0);
      chk("rst_left", 32'(left), 32'd0);
      chk("rst_pwm", 32'({pwm_l, pwm_r}), 32'd0);
      rst_n = 1'b1;
      step(6);

      // First fill: swap to half 1.
      filled = 1'b1;
      step(1);
      chk("swap1_sel", 32'(sel), 32'd1);
      chk("swap1_empty", 32'(empty), 32'd1);
      chk("swap1_addr", 32'(addr), 32'd0);
      filled = 1'b0;
      step(1);
      chk("swap1_empty_pulse", 32'(empty), 32'd0);

      // Frame 0: valid five cycles after the tick.
      wait_addr_move(n);
      wait_valid(n);
      chk("fetch_latency", 32'(n), 32'd4);
      chk("f0_left", 32'(left), 32'h1234);
      chk("f0_right", 32'(right), 32'h5678);

      // Frame 1: full-scale positive left; pause to measure PWM duty.
      wait_valid(n);
      chk("frame_period", 32'(n), 32'd16);
      chk("f1_left", 32'(left), 32'h7FFF);
      enable = 1'b0;
      step(4);
      measure_duty(hl, hr);
      chk("duty_l_7fff", 32'(hl), 32'(DUTY_7FFF));
      chk("duty_r_8000", 32'(hr), 32'(DUTY_8000));
      enable = 1'b1;

      // Frame 2: zero left gives mid-scale duty.
      wait_valid(n);
      chk("f2_left", 32'(left), 32'h0000);
      chk("f2_right", 32'(right), 32'h0001);
      enable = 1'b0;
      step(4);
      measure_duty(hl, hr);
      chk("duty_l_0000", 32'(hl), 32'(DUTY_0000));
      chk("duty_r_0001", 32'(hr), 32'(DUTY_0001));
      enable = 1'b1;
      filled = 1'b1;

      // Frame 3 wraps with half 0 ready: swap back to half 0.
      wait_valid(n);
      chk("f3_left", 32'(left), 32'hABCD);
      chk("f3_right", 32'(right), 32'h1357);
      chk("wrap_swap_empty", 32'(empty), 32'd1);
      chk("wrap_swap_sel", 32'(sel), 32'd0);
      chk("wrap_swap_addr", 32'(addr), 32'd0);
      filled = 1'b0;
      step(1);
      chk("wrap_empty_once", 32'(empty), 32'd0);

      // Pause 40 cycles right after a frame; tick resumes from the frozen count.
      wait_valid(n);
      chk("b0_left", 32'(left), 32'h1111);
      enable = 1'b0;
      a0 = addr;
      bad = 0;
      for (int i = 0; i < 40; i++) begin
         step(1);
         if (addr != a0 || valid) bad++;
      end
      chk("pause_quiet", 32'(bad), 32'd0);
      enable = 1'b1;
      wait_valid(n);
      chk("resume_tick", 32'(n), 32'd16);
      chk("b1_left", 32'(left), 32'h3333);
      wait_valid(n);
      chk("b2_left", 32'(left), 32'h5555);
      wait_valid(n);
      chk("b3_left", 32'(left), 32'hFEDC);
      chk("b3_right", 32'(right), 32'h0BA9);
      chk("b3_no_swap", 32'(empty), 32'd0);
      chk("b3_underrun", 32'(under), 32'd0);

      // Starved: three ticks repeat the held frame with underrun set.
      for (int i = 0; i < 3; i++) begin
         wait_valid(n);
         chk("ur_period", 32'(n), (i == 0) ? 32'd12 : 32'd16);
         chk("ur_flag", 32'(under), 32'd1);
         chk("ur_left", 32'(left), 32'hFEDC);
         chk("ur_right", 32'(right), 32'h0BA9);
         chk("ur_addr", 32'(addr), 32'd0);
      end
      filled = 1'b1;
      step(1);
      chk("ur_swap_sel", 32'(sel), 32'd1);
      chk("ur_swap_empty", 32'(empty), 32'd1);
      chk("ur_swap_clear", 32'(under), 32'd0);
      filled = 1'b0;

      // Reset in the middle of a fetch: no sample pulse survives.
      wait_addr_move(n);
      rst_n = 1'b0;
      step(2);
      chk("midrst_valid", 32'(valid), 32'd0);
      chk("midrst_sel", 32'(sel), 32'd0);
      chk("midrst_addr", 32'(addr), 32'd0);
      rst_n = 1'b1;
      bad = 0;
      for (int i = 0; i < 12; i++) begin
         step(1);
         if (valid) bad++;
      end
      chk("midrst_no_pulse", 32'(bad), 32'd0);

      // Playback restarts cleanly after the reset.
      filled = 1'b1;
      step(1);
      chk("restart_sel", 32'(sel), 32'd1);
      filled = 1'b0;
      wait_valid(n);
      chk("restart_left", 32'(left), 32'h1234);
      chk("restart_right", 32'(right), 32'h5678);
      step(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
